// File: rtl/glb_seg_stream_merger.sv
// Merges NUM_CH segment-mode block streams (header + payload, then done token) into one
// GLB-bound stream; one channel is locked per segment, round-robin, with an optional tag word.
module glb_seg_stream_merger #(
  parameter int              NUM_CH   = 4,
  parameter int              DATA_W   = 17,
  parameter int              MAX_SEG  = 512,
  parameter logic [DATA_W-1:0] DONE_TOK = 17'h10100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     flush,
  input  logic                     tile_en,
  input  logic                     tag_en,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic [15:0]              seg_count,
  output logic                     len_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] MAX_SEG_L = 16'(MAX_SEG);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_ARB, S_TAG, S_HDR, S_PAY, S_FIN, S_FWAIT, S_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
  logic [15:0]         rem_q, rem_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic [15:0]         seg_q, seg_d;
  logic                len_err_q, len_err_d;

  logic                active;
  logic                load_en;
  logic [DATA_W-1:0]   cur_word;
  logic [15:0]         hdr_len;
  logic [CH_W-1:0]     rr_next;
  logic                pick_found;
  logic [CH_W-1:0]     pick;

  assign active   = clk_en & tile_en & ~flush;
  assign load_en  = ~out_valid_q | out_ready;
  assign cur_word = in_data[grant_q*DATA_W +: DATA_W];
  assign hdr_len  = cur_word[15:0];
  assign rr_next  = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;

  // Round-robin pick: first valid, not-done channel at or after rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned idx;
      idx = 32'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_found && in_valid[idx] && !ch_done_q[idx]) begin
        pick_found = 1'b1;
        pick       = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    ch_done_d   = ch_done_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    seg_d       = seg_q;
    len_err_d   = len_err_q;
    in_ready    = '0;

    if (active) begin
      // An empty or drained output register goes invalid unless reloaded below.
      if (load_en) out_valid_d = 1'b0;

      unique case (state_q)
        S_ARB: begin
          if (&ch_done_q) begin
            state_d = S_FIN;
          end else if (pick_found) begin
            grant_d = pick;
            state_d = tag_en ? S_TAG : S_HDR;
          end
        end
        S_TAG: begin
          if (load_en) begin
            out_data_d  = DATA_W'(grant_q);
            out_valid_d = 1'b1;
            state_d     = S_HDR;
          end
        end
        S_HDR: begin
          if (load_en) begin
            in_ready[grant_q] = 1'b1;
            if (in_valid[grant_q]) begin
              if (cur_word == DONE_TOK) begin
                ch_done_d[grant_q] = 1'b1;
                rr_d               = rr_next;
                state_d            = S_ARB;
              end else begin
                out_data_d  = cur_word;
                out_valid_d = 1'b1;
                if (hdr_len > MAX_SEG_L) begin
                  len_err_d = 1'b1;
                  rem_d     = MAX_SEG_L;
                end else begin
                  rem_d     = hdr_len;
                end
                if (hdr_len == 16'd0) begin
                  seg_d   = seg_q + 16'd1;
                  rr_d    = rr_next;
                  state_d = S_ARB;
                end else begin
                  state_d = S_PAY;
                end
              end
            end
          end
        end
        S_PAY: begin
          if (load_en) begin
            in_ready[grant_q] = 1'b1;
            if (in_valid[grant_q]) begin
              out_data_d  = cur_word;
              out_valid_d = 1'b1;
              rem_d       = rem_q - 16'd1;
              if (rem_q == 16'd1) begin
                seg_d   = seg_q + 16'd1;
                rr_d    = rr_next;
                state_d = S_ARB;
              end
            end
          end
        end
        S_FIN: begin
          if (load_en) begin
            out_data_d  = DONE_TOK;
            out_valid_d = 1'b1;
            state_d     = S_FWAIT;
          end
        end
        S_FWAIT: begin
          if (out_ready) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_IDLE: ;
        default: state_d = S_ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ARB;
      grant_q     <= '0;
      rr_q        <= '0;
      ch_done_q   <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      seg_q       <= '0;
      len_err_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= S_ARB;
      grant_q     <= '0;
      rr_q        <= '0;
      ch_done_q   <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      seg_q       <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      ch_done_q   <= ch_done_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      seg_q       <= seg_d;
      len_err_q   <= len_err_d;
    end
  end

  // tile_en masks the visible valid only; the held word reappears when the tile resumes.
  assign out_valid = out_valid_q & tile_en;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign seg_count = seg_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_glb_seg_stream_merger.sv
// Directed bench for glb_seg_stream_merger: table of per-channel segment scenarios plus
// hand-written stall, freeze and asynchronous-reset sequences.
module tb_glb_seg_stream_merger;

  localparam int NCH = 4;
  localparam int DW  = 17;
  localparam logic [DW-1:0] DONE_W = 17'h10100;
  localparam int BUDGET = 20000;

  logic              clk = 1'b0;
  logic              rst_n, clk_en, flush, tile_en, tag_en;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid, in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid, out_ready, done, len_err;
  logic [15:0]       seg_count;

  always #5 clk = ~clk;

  glb_seg_stream_merger #(.NUM_CH(NCH), .DATA_W(DW), .MAX_SEG(512), .DONE_TOK(DONE_W)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .tag_en(tag_en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done),
    .seg_count(seg_count), .len_err(len_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] srcq [NCH][$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] expq[$];
  bit            stall_q;
  logic [DW-1:0] stall_data;

  typedef struct {
    string name;
    bit    tag;
    int    l0, l1, l2, l3;  // -1: channel sends only its done token
    bit    toggle;
    int    frz_kind;        // 0 none, 1 clk_en low, 2 tile_en low
    int    frz_at;
    int    exp_seg;
    bit    exp_err;
    int    exp_words;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int ch, input int j);
    logic [DW-1:0] w;
    w = DW'((ch << 12) | (j & 12'hfff));
    if (j == 0) w = w | 17'h10000;
    return w;
  endfunction

  function automatic int clamp(input int l);
    return (l > 512) ? 512 : l;
  endfunction

  task automatic load_src(input int l [NCH]);
    for (int c = 0; c < NCH; c++) begin
      srcq[c].delete();
      if (l[c] >= 0) begin
        srcq[c].push_back(DW'(l[c]));
        for (int j = 0; j < clamp(l[c]); j++) srcq[c].push_back(pay(c, j));
      end
      srcq[c].push_back(DONE_W);
    end
  endtask

  // All channels present from the start: first round visits ch0..3 in order (segment or
  // done token), second round consumes the remaining done tokens, then the final DONE.
  task automatic build_exp(input bit tag, input int l [NCH]);
    expq.delete();
    for (int c = 0; c < NCH; c++) begin
      if (tag) expq.push_back(DW'(c));
      if (l[c] >= 0) begin
        expq.push_back(DW'(l[c]));
        for (int j = 0; j < clamp(l[c]); j++) expq.push_back(pay(c, j));
      end
    end
    for (int c = 0; c < NCH; c++)
      if (tag && l[c] >= 0) expq.push_back(DW'(c));
    expq.push_back(DONE_W);
  endtask

  task automatic step(input bit toggle, input bit frz_clk, input bit frz_tile);
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      in_valid[i] = (srcq[i].size() > 0);
      in_data[i*DW +: DW] = in_valid[i] ? srcq[i][0] : '0;
    end
    out_ready = toggle ? ~out_ready : 1'b1;
    clk_en    = ~frz_clk;
    tile_en   = ~frz_tile;
    #4;
    if (stall_q && tile_en) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(stall_data));
    end
    if (frz_clk || frz_tile) check("frozen_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < NCH; i++)
      if (in_valid[i] && in_ready[i]) void'(srcq[i].pop_front());
    if (out_valid && out_ready && clk_en) got.push_back(out_data);
    stall_q    = out_valid && !out_ready;
    stall_data = out_data;
  endtask

  task automatic do_flush(input bit tag);
    @(negedge clk);
    flush = 1'b1; in_valid = '0; clk_en = 1'b1; tile_en = 1'b1; tag_en = tag; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_seg_count", 32'(seg_count), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_len_err", 32'(len_err), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int l [NCH];
    int cyc, frz_cnt;
    bit frz_started;
    l[0] = v.l0; l[1] = v.l1; l[2] = v.l2; l[3] = v.l3;
    do_flush(v.tag);
    load_src(l);
    build_exp(v.tag, l);
    got.delete();
    stall_q = 1'b0;
    cyc = 0; frz_cnt = 0; frz_started = 1'b0;
    while (!done && cyc < BUDGET) begin
      if (v.frz_kind != 0 && !frz_started && got.size() >= v.frz_at) begin
        frz_cnt = 10;
        frz_started = 1'b1;
      end
      step(v.toggle, v.frz_kind == 1 && frz_cnt > 0, v.frz_kind == 2 && frz_cnt > 0);
      if (frz_cnt > 0) frz_cnt--;
      cyc++;
    end
    check({v.name, "_timeout"}, 32'(cyc < BUDGET), 32'd1);
    check({v.name, "_words"}, 32'(got.size()), 32'(v.exp_words));
    check({v.name, "_model_words"}, 32'(expq.size()), 32'(v.exp_words));
    for (int k = 0; k < expq.size(); k++) begin
      if (k < got.size()) check($sformatf("%s_w%0d", v.name, k), 32'(got[k]), 32'(expq[k]));
    end
    check({v.name, "_seg_count"}, 32'(seg_count), 32'(v.exp_seg));
    check({v.name, "_len_err"}, 32'(len_err), 32'(v.exp_err));
    check({v.name, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({v.name, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({v.name, "_idle_ready"}, 32'(in_ready), 32'd0);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"four_segs",   1'b0,  2,  2,  2,  2, 1'b0, 0,  0, 4, 1'b0, 13};
    vecs[1] = '{"tag_ch2",     1'b1, -1, -1,  1, -1, 1'b0, 0,  0, 1, 1'b0, 8};
    vecs[2] = '{"zero_len",    1'b0,  0,  0, -1, -1, 1'b0, 0,  0, 2, 1'b0, 3};
    vecs[3] = '{"over_max",    1'b0, -1, 600, 3, -1, 1'b0, 0,  0, 2, 1'b1, 518};
    vecs[4] = '{"tag_two",     1'b1,  5, -1, -1,  7, 1'b0, 0,  0, 2, 1'b0, 21};
    vecs[5] = '{"all_done",    1'b0, -1, -1, -1, -1, 1'b0, 0,  0, 0, 1'b0, 1};
    vecs[6] = '{"toggle_300",  1'b0, -1, 300, -1, -1, 1'b1, 0, 0, 1, 1'b0, 302};
    vecs[7] = '{"clk_en_frz",  1'b0, -1, 40, -1, -1, 1'b0, 1, 10, 1, 1'b0, 42};
    vecs[8] = '{"tile_en_frz", 1'b1, -1, 40, -1, -1, 1'b0, 2, 10, 1, 1'b0, 47};

    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1; tag_en = 1'b0;
    in_data = '0; in_valid = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_seg_count", 32'(seg_count), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of ch1's payload.
    begin
      int l [NCH];
      int cyc;
      l[0] = 0; l[1] = 20; l[2] = -1; l[3] = -1;
      do_flush(1'b0);
      load_src(l);
      got.delete();
      stall_q = 1'b0;
      cyc = 0;
      while (got.size() < 8 && cyc < 200) begin
        step(1'b0, 1'b0, 1'b0);
        cyc++;
      end
      check("arst_timeout", 32'(cyc < 200), 32'd1);
      check("arst_w0", 32'(got[0]), 32'd0);
      check("arst_w1", 32'(got[1]), 32'd20);
      check("arst_w2", 32'(got[2]), 32'(pay(1, 0)));
      check("arst_pre_seg", 32'(seg_count), 32'd1);
      check("arst_pre_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data", 32'(out_data), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd0);
      check("arst_seg_count", 32'(seg_count), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < NCH; c++) srcq[c].delete();
    end

    // Fresh run after the reset must behave normally.
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
